vote_encrypt_scheduler: RTL and testbench
=========================================

// Module: vote_encrypt_scheduler
// PURPOSE
//  Shares one candidate encryptor between NUM_VOTERS ballot sources; one vote encrypted at a time.
//  Round-robin arbitration picks a voter, then streams NUM_BLOCKS exponentiator (r^n mod n^2) blocks with the vote bit.
//  Walks BRAM addresses of k and n^2 constant blocks on the encryptor's consumed pulses.
//  Forwards ciphertext blocks tagged with voter id and a last flag. Sits between ballot front-end and tally accumulator.
// PARAMETERS
//  REGISTER_SIZE  32    width of one data block
//  BITS_IN_NUM    4096  bit width of n; ciphertext is mod n^2
//  NUM_VOTERS     4     number of ballot requesters (>=2)
//  NUM_BLOCKS     = 2*BITS_IN_NUM/REGISTER_SIZE (256), localparam, blocks per exponentiator/ciphertext
// PORTS
//  clk_in             in   1                 single clock
//  rst_in             in   1                 asynchronous, active-high reset
//  vote_valid_in      in   NUM_VOTERS        voter i requests encryption
//  vote_candidate_in  in   NUM_VOTERS        voter i's vote bit (1 = candidate chosen)
//  vote_ready_out     out  NUM_VOTERS        one-hot, 1-cycle grant; vote captured that cycle
//  expo_valid_in      in   1                 exponentiator block available
//  expo_data_in       in   REGISTER_SIZE     exponentiator block, LSB block first
//  expo_ready_out     out  1                 exponentiator block consumed this cycle
//  enc_valid_out      out  1                 to encryptor valid_in
//  enc_candidate_out  out  1                 to encryptor candidate_in, held for whole job
//  enc_expo_out       out  REGISTER_SIZE     to encryptor exponentiator_in
//  enc_consumed_k_in  in   1                 encryptor consumed a k block
//  enc_consumed_n_in  in   1                 encryptor consumed an n^2 block
//  enc_valid_in       in   1                 encryptor valid_out
//  enc_data_in        in   REGISTER_SIZE     encryptor data_out
//  k_addr_out         out  $clog2(NUM_BLOCKS) k constant BRAM address
//  n_sq_addr_out      out  $clog2(NUM_BLOCKS) n^2 constant BRAM address
//  result_valid_out   out  1                 ciphertext block valid
//  result_data_out    out  REGISTER_SIZE     ciphertext block
//  result_voter_out   out  $clog2(NUM_VOTERS) voter id of current job
//  result_last_out    out  1                 marks block NUM_BLOCKS-1
//  busy_out           out  1                 high outside IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; rr pointer=0; all counters, addresses and outputs 0.
//  FSM IDLE -> GRANT -> LOAD -> DRAIN -> IDLE.
//   IDLE: any vote_valid_in bit set -> GRANT next cycle.
//   GRANT (1 cycle): pick first requester at or after rr_ptr, wrapping. Pulse its vote_ready_out.
//     Latch its candidate bit and id. Set rr_ptr = id+1 mod NUM_VOTERS. Clear in/out counters and both addresses.
//   LOAD: enc_valid_out = expo_ready_out = expo_valid_in; enc_expo_out = expo_data_in (combinational pass).
//     in_cnt++ per accepted block. Gaps allowed. After block NUM_BLOCKS-1 is accepted -> DRAIN.
//   DRAIN: enc_valid_out=0, expo_ready_out=0. Exit to IDLE on the cycle after result_last_out.
//  Output path: result_valid_out=enc_valid_in and result_data_out=enc_data_in, registered (1-cycle latency).
//   out_cnt counts result blocks. result_last_out is set with block NUM_BLOCKS-1. No backpressure.
//  Candidate 0: encryptor output is combinational, so result blocks begin during LOAD.
//   out_cnt counts in LOAD and in DRAIN; if out_cnt is already complete when LOAD ends, DRAIN lasts 1 cycle.
//  Addresses: k_addr_out increments on enc_consumed_k_in; n_sq_addr_out increments on enc_consumed_n_in.
//   Both wrap NUM_BLOCKS-1 -> 0 and are independent. Consumed pulses in IDLE are ignored.
//  Simultaneous events: consumed pulses coincident with GRANT are dropped (clear wins).
//   enc_valid_in in IDLE or GRANT is ignored and flagged in sim by an assertion.
//  A requester that drops vote_valid_in before its grant is skipped. A vote is never granted twice without re-request.
//  Reset mid-job: the job is abandoned with no partial result_last_out. The encryptor is reset by the same rst_in.
// CONFIGURATION
//  VOTE_TALLY_EN defined: adds port tally_out [15:0]. It counts completed jobs with candidate=1.
//   It increments on the result_last_out cycle, saturates at 16'hFFFF and resets to 0.
//  Not defined: no port and no counter. All other behaviour is identical.
// STRUCTURE
//  Package vote_sched_pkg: state_t enum {IDLE,GRANT,LOAD,DRAIN}; NUM_BLOCKS function;
//   BLK_IDX_W = $clog2(NUM_BLOCKS).
//  Sub-module rr_arbiter (NUM_VOTERS): req vector + pointer -> one-hot grant + id, purely combinational.
// TESTING (NUM_VOTERS=4, NUM_BLOCKS=256, behavioural encryptor model)
//  1. Voter 2 valid, candidate=0, expo 0..255 -> grant[2] pulse; 256 result blocks equal expo data.
//     last on 256th; busy drops the cycle after last.
//  2. Voters 0,1,3 request together -> grants in order 0,1,3. Re-request of 0 during job 3 -> granted after 3.
//  3. Candidate=1, model pulses consumed_k 300 times -> k_addr wraps 255->0, ends at 44; n_sq_addr tracks its own pulses.
//  4. expo_valid_in toggles every cycle -> exactly 256 enc_valid_out beats; no duplicate or dropped block.
//  5. rst_in asserted at in_cnt=100 -> outputs 0 asynchronously. Next job starts at rr_ptr=0 with addresses 0.
//  6. VOTE_TALLY_EN defined, 3 jobs with votes 1,0,1 -> tally_out=2.

Source files
------------

// File: rtl/vote_sched_pkg.sv
// Shared types and sizing helpers for the vote encryption scheduler.
// Optional tally counter in the top is enabled by defining VOTE_TALLY_EN.
package vote_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOAD,
        DRAIN
    } state_t;

    // Blocks per exponentiator / ciphertext value (ciphertext lives mod n^2).
    function automatic int num_blocks(input int bits_in_num, input int register_size);
        return (2 * bits_in_num) / register_size;
    endfunction

    localparam int NUM_BLOCKS_DEFAULT = num_blocks(4096, 32);
    localparam int BLK_IDX_W          = $clog2(NUM_BLOCKS_DEFAULT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping.
module rr_arbiter #(
    parameter int NUM_VOTERS = 4
) (
    input  logic [NUM_VOTERS-1:0]         req,
    input  logic [$clog2(NUM_VOTERS)-1:0] ptr,
    output logic [NUM_VOTERS-1:0]         grant,
    output logic [$clog2(NUM_VOTERS)-1:0] id,
    output logic                          any
);

    localparam int VOTER_W = $clog2(NUM_VOTERS);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            idx = (int'(ptr) + i) % NUM_VOTERS;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = VOTER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vote_encrypt_scheduler.sv
// Shares one encryptor between NUM_VOTERS ballot sources, one vote job at a time.
// Define VOTE_TALLY_EN to add tally_out, a saturating count of completed candidate=1 jobs.
module vote_encrypt_scheduler
    import vote_sched_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    parameter int NUM_VOTERS    = 4
) (
    input  logic                                                   clk_in,
    input  logic                                                   rst_in,
    input  logic [NUM_VOTERS-1:0]                                  vote_valid_in,
    input  logic [NUM_VOTERS-1:0]                                  vote_candidate_in,
    output logic [NUM_VOTERS-1:0]                                  vote_ready_out,
    input  logic                                                   expo_valid_in,
    input  logic [REGISTER_SIZE-1:0]                               expo_data_in,
    output logic                                                   expo_ready_out,
    output logic                                                   enc_valid_out,
    output logic                                                   enc_candidate_out,
    output logic [REGISTER_SIZE-1:0]                               enc_expo_out,
    input  logic                                                   enc_consumed_k_in,
    input  logic                                                   enc_consumed_n_in,
    input  logic                                                   enc_valid_in,
    input  logic [REGISTER_SIZE-1:0]                               enc_data_in,
    output logic [$clog2(num_blocks(BITS_IN_NUM, REGISTER_SIZE))-1:0] k_addr_out,
    output logic [$clog2(num_blocks(BITS_IN_NUM, REGISTER_SIZE))-1:0] n_sq_addr_out,
    output logic                                                   result_valid_out,
    output logic [REGISTER_SIZE-1:0]                               result_data_out,
    output logic [$clog2(NUM_VOTERS)-1:0]                          result_voter_out,
    output logic                                                   result_last_out,
    output logic                                                   busy_out
`ifdef VOTE_TALLY_EN
    ,
    output logic [15:0]                                            tally_out
`endif
);

    localparam int NUM_BLOCKS = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
    localparam int ADDR_W     = $clog2(NUM_BLOCKS);
    localparam int VOTER_W    = $clog2(NUM_VOTERS);

    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [VOTER_W-1:0] LAST_VOTER = VOTER_W'(NUM_VOTERS - 1);

    state_t              state, next_state;
    logic [VOTER_W-1:0]  rr_ptr;
    logic [VOTER_W-1:0]  voter_id;
    logic                candidate;
    logic [ADDR_W-1:0]   in_cnt;
    logic [ADDR_W-1:0]   out_cnt;
    logic                out_done;

    logic [NUM_VOTERS-1:0] grant;
    logic [VOTER_W-1:0]    grant_id;
    logic                  grant_any;

    logic load_accept;
    logic job_live;
    logic capture_result;

    rr_arbiter #(
        .NUM_VOTERS(NUM_VOTERS)
    ) u_arbiter (
        .req   (vote_valid_in),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (grant_id),
        .any   (grant_any)
    );

    assign job_live       = (state == LOAD) || (state == DRAIN);
    assign load_accept    = (state == LOAD) && expo_valid_in;
    // Encryptor output outside a job is spurious and never reaches the result port.
    assign capture_result = job_live && enc_valid_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|vote_valid_in) next_state = GRANT;
            GRANT:   next_state = grant_any ? LOAD : IDLE;
            LOAD:    if (load_accept && (in_cnt == LAST_IDX)) next_state = DRAIN;
            DRAIN:   if (out_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        vote_ready_out = '0;
        enc_valid_out  = 1'b0;
        expo_ready_out = 1'b0;
        enc_expo_out   = '0;
        case (state)
            GRANT: vote_ready_out = grant;
            LOAD: begin
                enc_valid_out  = expo_valid_in;
                expo_ready_out = expo_valid_in;
                enc_expo_out   = expo_data_in;
            end
            default: ;
        endcase
    end

    assign busy_out          = (state != IDLE);
    assign enc_candidate_out = candidate;
    assign result_voter_out  = voter_id;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr           <= '0;
            voter_id         <= '0;
            candidate        <= 1'b0;
            in_cnt           <= '0;
            out_cnt          <= '0;
            out_done         <= 1'b0;
            k_addr_out       <= '0;
            n_sq_addr_out    <= '0;
            result_valid_out <= 1'b0;
            result_data_out  <= '0;
            result_last_out  <= 1'b0;
        end else begin
            if (state == GRANT) begin
                // Clearing wins over any consumed pulse landing in the grant cycle.
                in_cnt        <= '0;
                out_cnt       <= '0;
                out_done      <= 1'b0;
                k_addr_out    <= '0;
                n_sq_addr_out <= '0;
                if (grant_any) begin
                    candidate <= vote_candidate_in[grant_id];
                    voter_id  <= grant_id;
                    rr_ptr    <= (grant_id == LAST_VOTER) ? '0 : grant_id + 1'b1;
                end
            end else begin
                if (load_accept) in_cnt <= in_cnt + 1'b1;
                if (job_live && enc_consumed_k_in)
                    k_addr_out <= (k_addr_out == LAST_IDX) ? '0 : k_addr_out + 1'b1;
                if (job_live && enc_consumed_n_in)
                    n_sq_addr_out <= (n_sq_addr_out == LAST_IDX) ? '0 : n_sq_addr_out + 1'b1;
                if (capture_result) begin
                    out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + 1'b1;
                    if (out_cnt == LAST_IDX) out_done <= 1'b1;
                end
            end
            result_valid_out <= capture_result;
            result_data_out  <= capture_result ? enc_data_in : '0;
            result_last_out  <= capture_result && (out_cnt == LAST_IDX);
        end
    end

`ifdef VOTE_TALLY_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tally_out <= '0;
        end else if (result_last_out && candidate && (tally_out != 16'hFFFF)) begin
            tally_out <= tally_out + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_result_outside_job : assert property (@(posedge clk_in) disable iff (rst_in)
        !(enc_valid_in && ((state == IDLE) || (state == GRANT))));
`endif

endmodule

// File: tb/tb_vote_encrypt_scheduler.sv
// Directed bench for vote_encrypt_scheduler with a behavioural encryptor model.
// Define VOTE_TALLY_EN to also exercise the tally counter.
module tb_vote_encrypt_scheduler;

    localparam int NB = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vote_valid;
    logic [3:0]  vote_cand;
    logic [3:0]  vote_ready;
    logic        expo_valid;
    logic [31:0] expo_data;
    logic        expo_ready;
    logic        enc_valid_o;
    logic        enc_cand;
    logic [31:0] enc_expo;
    logic        cons_k;
    logic        cons_n;
    logic        enc_valid_i;
    logic [31:0] enc_data_i;
    logic [7:0]  k_addr;
    logic [7:0]  n_addr;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_voter;
    logic        res_last;
    logic        busy;
`ifdef VOTE_TALLY_EN
    logic [15:0] tally;
`endif

    // Encryptor model: combinational pass-through, or bench-driven output blocks.
    logic        comb_mode;
    logic        tb_valid;
    logic [31:0] tb_data;
    assign enc_valid_i = comb_mode ? enc_valid_o : tb_valid;
    assign enc_data_i  = comb_mode ? enc_expo    : tb_data;

    int tests_run    = 0;
    int tests_failed = 0;

    vote_encrypt_scheduler dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .vote_valid_in     (vote_valid),
        .vote_candidate_in (vote_cand),
        .vote_ready_out    (vote_ready),
        .expo_valid_in     (expo_valid),
        .expo_data_in      (expo_data),
        .expo_ready_out    (expo_ready),
        .enc_valid_out     (enc_valid_o),
        .enc_candidate_out (enc_cand),
        .enc_expo_out      (enc_expo),
        .enc_consumed_k_in (cons_k),
        .enc_consumed_n_in (cons_n),
        .enc_valid_in      (enc_valid_i),
        .enc_data_in       (enc_data_i),
        .k_addr_out        (k_addr),
        .n_sq_addr_out     (n_addr),
        .result_valid_out  (res_valid),
        .result_data_out   (res_data),
        .result_voter_out  (res_voter),
        .result_last_out   (res_last),
        .busy_out          (busy)
`ifdef VOTE_TALLY_EN
        ,
        .tally_out         (tally)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  voter;
    } res_t;
    res_t results[$];

    always @(negedge clk) begin
        if (res_valid) results.push_back('{res_data, res_last, res_voter});
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    function automatic int result_errors(input logic [31:0] base, input logic [1:0] voter);
        int errs = 0;
        for (int i = 0; i < results.size(); i++) begin
            if (results[i].data !== base + 32'(i) || results[i].last !== (i == NB - 1) ||
                results[i].voter !== voter)
                errs++;
        end
        return errs;
    endfunction

    task automatic apply_reset();
        rst        = 1'b1;
        vote_valid = '0;
        vote_cand  = '0;
        expo_valid = 1'b0;
        expo_data  = '0;
        cons_k     = 1'b0;
        cons_n     = 1'b0;
        tb_valid   = 1'b0;
        tb_data    = '0;
        comb_mode  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        results.delete();
    endtask

    // Waits for a grant pulse, then withdraws that request after the grant edge.
    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int c = 0; c < 20 && g == 4'b0; c++) begin
            @(negedge clk);
            #1;
            g = vote_ready;
        end
        if (g != 4'b0) begin
            @(posedge clk);
            #1;
            vote_valid = vote_valid & ~g;
        end
    endtask

    task automatic feed(input bit toggle, input logic [31:0] base, input bit pulse_k,
                        input int limit, output int beats, output int bad);
        int acc = 0;
        beats = 0;
        bad   = 0;
        for (int c = 0; c < 1200 && acc < limit; c++) begin
            @(negedge clk);
            expo_valid = toggle ? (c % 2 == 0) : 1'b1;
            expo_data  = base + 32'(acc);
            cons_k     = pulse_k;
            #1;
            if (enc_valid_o) begin
                beats++;
                if (enc_expo !== expo_data || expo_ready !== 1'b1) bad++;
            end
            if (enc_valid_o !== expo_valid) bad++;
            if (expo_valid) acc++;
        end
        @(negedge clk);
        expo_valid = 1'b0;
        cons_k     = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vote_valid = '0; vote_cand = '0; expo_valid = 1'b0; expo_data = '0;
        cons_k = 1'b0; cons_n = 1'b0; tb_valid = 1'b0; tb_data = '0; comb_mode = 1'b1;
        #1;
        tests_run++;
        if ({busy, vote_ready, enc_valid_o, expo_ready, enc_cand} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, vote_ready, enc_valid_o, expo_ready, enc_cand});
        end
        tests_run++;
        if ({k_addr, n_addr} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h expected 0000", {k_addr, n_addr});
        end
        tests_run++;
        if ({res_valid, res_last, res_voter, res_data} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 0", {res_valid, res_last, res_voter, res_data});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_job();
        logic [3:0] g;
        int beats, bad, errs;
        bit ok;
        apply_reset();
        vote_valid = 4'b0100;
        wait_grant(g);
        tests_run++;
        if (g !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant: got %b expected 0100", g);
        end
        feed(1'b0, 32'h0, 1'b0, NB, beats, bad);
        tests_run++;
        if (beats !== NB || bad !== 0) begin
            tests_failed++;
            $display("FAIL single_load: beats %0d bad %0d expected %0d and 0", beats, bad, NB);
        end
        tests_run++;
        if ({res_last, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL single_last: last,busy got %b expected 11", {res_last, busy});
        end
        @(negedge clk);
        tests_run++;
        if ({res_last, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_busy_drop: last,busy got %b expected 00", {res_last, busy});
        end
        errs = result_errors(32'h0, 2'd2);
        tests_run++;
        if (results.size() !== NB || errs !== 0) begin
            tests_failed++;
            $display("FAIL single_results: count %0d errors %0d expected %0d and 0",
                     results.size(), errs, NB);
        end
        wait_idle(ok);
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] exp_g[4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        int beats, bad;
        bit ok;
        apply_reset();
        vote_valid = 4'b1011;
        for (int j = 0; j < 4; j++) begin
            wait_grant(g);
            tests_run++;
            if (g !== exp_g[j]) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got %b expected %b", j, g, exp_g[j]);
            end
            if (j == 2) vote_valid[0] = 1'b1;
            feed(1'b0, 32'h1000 * j, 1'b0, NB, beats, bad);
            wait_idle(ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL rr_idle_%0d: busy got 1 expected 0 within bound", j);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({busy, vote_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rr_no_regrant: busy,ready got %b expected 00000", {busy, vote_ready});
        end
    endtask

    task automatic test_addr_wrap();
        logic [3:0] g;
        int beats, bad, errs;
        bit ok;
        apply_reset();
        comb_mode  = 1'b0;
        vote_cand  = 4'b0010;
        vote_valid = 4'b0010;
        wait_grant(g);
        tests_run++;
        if (g !== 4'b0010 || enc_cand !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_grant: grant %b cand %b expected 0010 and 1", g, enc_cand);
        end
        feed(1'b0, 32'h100, 1'b0, NB, beats, bad);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 255) begin
                tests_run++;
                if (k_addr !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL k_addr_top: got %0d expected 255", k_addr);
                end
            end
            if (i == 256) begin
                tests_run++;
                if (k_addr !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL k_addr_wrap: got %0d expected 0", k_addr);
                end
            end
            cons_k = 1'b1;
            cons_n = (i < 70);
        end
        @(negedge clk);
        cons_k = 1'b0;
        cons_n = 1'b0;
        tests_run++;
        if (k_addr !== 8'd44 || n_addr !== 8'd70) begin
            tests_failed++;
            $display("FAIL addr_final: k %0d n %0d expected 44 and 70", k_addr, n_addr);
        end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            tb_valid = 1'b1;
            tb_data  = 32'hC000_0000 + 32'(i);
        end
        @(negedge clk);
        tb_valid = 1'b0;
        tests_run++;
        if (res_last !== 1'b1 || res_voter !== 2'd1) begin
            tests_failed++;
            $display("FAIL addr_job_last: last %b voter %0d expected 1 and 1", res_last, res_voter);
        end
        wait_idle(ok);
        errs = result_errors(32'hC000_0000, 2'd1);
        tests_run++;
        if (!ok || results.size() !== NB || errs !== 0) begin
            tests_failed++;
            $display("FAIL addr_results: idle %b count %0d errors %0d expected 1, %0d, 0",
                     ok, results.size(), errs, NB);
        end
        cons_k = 1'b1;
        @(negedge clk);
        cons_k = 1'b0;
        @(negedge clk);
        tests_run++;
        if (k_addr !== 8'd44) begin
            tests_failed++;
            $display("FAIL addr_idle_ignore: got %0d expected 44", k_addr);
        end
        comb_mode = 1'b1;
    endtask

    task automatic test_toggle();
        logic [3:0] g;
        int beats, bad, extra, errs;
        bit ok;
        apply_reset();
        vote_valid = 4'b1000;
        wait_grant(g);
        feed(1'b1, 32'h5000, 1'b0, NB, beats, bad);
        tests_run++;
        if (beats !== NB || bad !== 0) begin
            tests_failed++;
            $display("FAIL toggle_beats: beats %0d bad %0d expected %0d and 0", beats, bad, NB);
        end
        extra = 0;
        expo_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (enc_valid_o || expo_ready) extra++;
        end
        expo_valid = 1'b0;
        wait_idle(ok);
        errs = result_errors(32'h5000, 2'd3);
        tests_run++;
        if (extra !== 0 || results.size() !== NB || errs !== 0) begin
            tests_failed++;
            $display("FAIL toggle_results: extra %0d count %0d errors %0d expected 0, %0d, 0",
                     extra, results.size(), errs, NB);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [3:0] g;
        int beats, bad, lasts, errs;
        bit ok;
        apply_reset();
        vote_valid = 4'b0010;
        wait_grant(g);
        feed(1'b0, 32'h7000, 1'b1, 100, beats, bad);
        tests_run++;
        if (k_addr !== 8'd100 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midjob_pre: k %0d busy %b expected 100 and 1", k_addr, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, res_valid, res_last, k_addr, n_addr, enc_valid_o, expo_ready, vote_ready} !== 25'h0) begin
            tests_failed++;
            $display("FAIL midjob_async: got %h expected 0",
                     {busy, res_valid, res_last, k_addr, n_addr, enc_valid_o, expo_ready, vote_ready});
        end
        lasts = 0;
        foreach (results[i]) if (results[i].last) lasts++;
        tests_run++;
        if (lasts !== 0) begin
            tests_failed++;
            $display("FAIL midjob_no_last: got %0d last flags expected 0", lasts);
        end
        @(negedge clk);
        rst = 1'b0;
        results.delete();
        vote_valid = 4'b1001;
        wait_grant(g);
        tests_run++;
        if (g !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midjob_rr_reset: got %b expected 0001", g);
        end
        vote_valid = 4'b0000;
        feed(1'b0, 32'h9000, 1'b0, NB, beats, bad);
        wait_idle(ok);
        errs = result_errors(32'h9000, 2'd0);
        tests_run++;
        if (!ok || results.size() !== NB || errs !== 0) begin
            tests_failed++;
            $display("FAIL midjob_next: idle %b count %0d errors %0d expected 1, %0d, 0",
                     ok, results.size(), errs, NB);
        end
    endtask

`ifdef VOTE_TALLY_EN
    task automatic test_tally();
        logic [3:0] g;
        logic       votes[3] = '{1'b1, 1'b0, 1'b1};
        int beats, bad;
        bit ok;
        apply_reset();
        tests_run++;
        if (tally !== 16'd0) begin
            tests_failed++;
            $display("FAIL tally_reset: got %0d expected 0", tally);
        end
        for (int j = 0; j < 3; j++) begin
            vote_cand  = {3'b000, votes[j]};
            vote_valid = 4'b0001;
            wait_grant(g);
            feed(1'b0, 32'h0, 1'b0, NB, beats, bad);
            wait_idle(ok);
        end
        @(negedge clk);
        tests_run++;
        if (tally !== 16'd2) begin
            tests_failed++;
            $display("FAIL tally_count: got %0d expected 2", tally);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_addr_wrap();
        test_toggle();
        test_reset_mid_job();
`ifdef VOTE_TALLY_EN
        test_tally();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
